// File: rtl/comb_feedback_line.sv
// Feedback comb stage: y[n] = sat(x[n] + g*y[n-D]), circular sample buffer.
// Optional COMB_ROUND_EN: feedback term rounds half up instead of flooring.
module comb_feedback_line #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int GAIN_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] delay,
    input  logic [GAIN_W-1:0] filterMul,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy
);

    localparam int PW    = DATA_W + GAIN_W + 1;
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic signed [PW-1:0] SMAX =
        {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PW-1:0] SMIN =
        {{(PW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_READ,
        S_MUL,
        S_SUM,
        S_OUT
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [ADDR_W-1:0]      r_wr_ptr;
    logic [ADDR_W-1:0]      r_clr_cnt;
    logic [ADDR_W-1:0]      r_deff;
    logic [GAIN_W-1:0]      r_g;
    logic [DATA_W-1:0]      r_x;
    logic [DATA_W-1:0]      r_q;
    logic signed [PW-1:0]   r_fb;
    logic [DATA_W-1:0]      r_out;
    logic                   r_out_valid;
    logic [DATA_W-1:0]      r_mem [DEPTH];

    logic [ADDR_W-1:0]      w_rd_addr;
    logic signed [PW-1:0]   w_a;
    logic signed [PW-1:0]   w_b;
    logic signed [PW-1:0]   w_prod;
    logic signed [PW-1:0]   w_prod_adj;
    logic signed [PW-1:0]   w_fb;
    logic signed [PW-1:0]   w_sum;
    logic [DATA_W-1:0]      w_y;
    logic                   w_we;
    logic [ADDR_W-1:0]      w_waddr;
    logic [DATA_W-1:0]      w_wdata;

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state == S_CLEAR);
    assign out_valid = r_out_valid;
    assign out_data  = r_out;

    // D_eff >= 1, so the read address never collides with the write pointer
    assign w_rd_addr = r_wr_ptr - r_deff;

    assign w_a    = {{(PW-DATA_W){r_q[DATA_W-1]}}, r_q};
    assign w_b    = {{(PW-GAIN_W){1'b0}}, r_g};
    assign w_prod = w_a * w_b;

`ifdef COMB_ROUND_EN
    assign w_prod_adj = w_prod + (PW'(1) <<< (GAIN_W-2));
`else
    assign w_prod_adj = w_prod;
`endif

    assign w_fb  = w_prod_adj >>> (GAIN_W-1);
    assign w_sum = {{(PW-DATA_W){r_x[DATA_W-1]}}, r_x} + r_fb;

    always_comb begin
        w_y = w_sum[DATA_W-1:0];
        if (w_sum > SMAX)
            w_y = SMAX[DATA_W-1:0];
        else if (w_sum < SMIN)
            w_y = SMIN[DATA_W-1:0];
    end

    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_wr_ptr;
        w_wdata = w_y;
        if (!clear) begin
            if (r_state == S_CLEAR) begin
                w_we    = 1'b1;
                w_waddr = r_clr_cnt;
                w_wdata = '0;
            end else if (r_state == S_SUM) begin
                w_we = 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        if (clear) begin
            w_next = S_CLEAR;
        end else begin
            unique case (r_state)
                S_CLEAR: if (r_clr_cnt == '1) w_next = S_IDLE;
                S_IDLE:  if (in_valid) w_next = S_READ;
                S_READ:  w_next = S_MUL;
                S_MUL:   w_next = S_SUM;
                S_SUM:   w_next = S_OUT;
                S_OUT:   if (out_ready) w_next = S_IDLE;
                default: w_next = S_CLEAR;
            endcase
        end
    end

    // Buffer contents are not reset; the CLEAR sweep zeroes them
    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[w_waddr] <= w_wdata;
        if (r_state == S_READ)
            r_q <= r_mem[w_rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_CLEAR;
            r_wr_ptr    <= '0;
            r_clr_cnt   <= '0;
            r_deff      <= ADDR_W'(1);
            r_g         <= '0;
            r_x         <= '0;
            r_fb        <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            if (clear) begin
                r_clr_cnt   <= '0;
                r_out_valid <= 1'b0;
            end else begin
                unique case (r_state)
                    S_CLEAR: begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                        if (r_clr_cnt == '1)
                            r_wr_ptr <= '0;
                    end
                    S_IDLE: begin
                        if (in_valid) begin
                            r_x    <= in_data;
                            r_deff <= (delay == '0) ? ADDR_W'(1) : delay;
                            r_g    <= filterMul;
                        end
                    end
                    S_MUL: r_fb <= w_fb;
                    S_SUM: begin
                        r_out       <= w_y;
                        r_out_valid <= 1'b1;
                        r_wr_ptr    <= r_wr_ptr + 1'b1;
                    end
                    S_OUT: begin
                        if (out_ready)
                            r_out_valid <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_comb_feedback_line.sv
// Directed-vector bench for comb_feedback_line (floor or rounded feedback).
module tb_comb_feedback_line;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  delay;
    logic [10:0] filterMul;
    logic        clear;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic        busy;

    int nvec = 0;
    int nmis = 0;

    typedef struct {
        bit clr;
        int x;
        int d;
        int g;
        int y;
    } vec_t;

    vec_t vecs [20];

    always #5 clk = ~clk;

    comb_feedback_line dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .delay     (delay),
        .filterMul (filterMul),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_clear_done(input string name);
        int n = 0;
        while (busy && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, n, 1024);
        chk({name, "_rdy"}, int'(in_ready), 1);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        wait_clear_done("clear_busy");
    endtask

    task automatic send(input int x, input int d, input int g,
                        output int y, output int lat);
        int n = 0;
        in_data   = 16'(x);
        delay     = 10'(d);
        filterMul = 11'(g);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (!in_ready && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        y = $signed(out_data);
        @(posedge clk); #1;
    endtask

    task automatic run_rows(input int lo, input int hi, input bit honor);
        int y;
        int lat;
        for (int i = lo; i <= hi; i++) begin
            if (honor && vecs[i].clr)
                do_clear();
            send(vecs[i].x, vecs[i].d, vecs[i].g, y, lat);
            chk($sformatf("lat[%0d]", i), lat, 4);
            chk($sformatf("y[%0d]", i), y, vecs[i].y);
            chk($sformatf("drop[%0d]", i), int'(out_valid), 0);
        end
    endtask

    initial begin
        int n;
        int y0;
        bit seen;

        vecs[0]  = '{0, 0, 5, 1022, 0};
        vecs[1]  = '{1, 16384, 4, 1022, 16384};
        vecs[2]  = '{0, 0, 4, 1022, 0};
        vecs[3]  = '{0, 0, 4, 1022, 0};
        vecs[4]  = '{0, 0, 4, 1022, 0};
        vecs[5]  = '{0, 0, 4, 1022, 16352};
        vecs[6]  = '{0, 0, 4, 1022, 0};
        vecs[7]  = '{0, 0, 4, 1022, 0};
        vecs[8]  = '{0, 0, 4, 1022, 0};
        vecs[9]  = '{0, 0, 4, 1022, 16320};
        vecs[10] = '{1, 30000, 1, 1022, 30000};
        vecs[11] = '{0, 30000, 1, 1022, 32767};
        vecs[12] = '{1, -30000, 1, 1022, -30000};
        vecs[13] = '{0, -30000, 1, 1022, -32768};
        vecs[14] = '{1, 1000, 0, 1024, 1000};
        vecs[15] = '{0, 0, 0, 1024, 1000};
        vecs[16] = '{1, -1, 1, 1022, -1};
        vecs[17] = '{0, -1, 1, 1022, -2};
        vecs[18] = '{1, 100, 1, 1022, 100};
`ifdef COMB_ROUND_EN
        vecs[19] = '{0, 100, 1, 1022, 200};
`else
        vecs[19] = '{0, 100, 1, 1022, 199};
`endif

        rst_n     = 1'b0;
        delay     = '0;
        filterMul = '0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 1);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        rst_n = 1'b1;
        wait_clear_done("reset_busy");

        run_rows(0, 19, 1'b1);

        // backpressure: g=0 makes y equal x
        in_data   = 16'(1234);
        delay     = 10'(1);
        filterMul = '0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        y0 = $signed(out_data);
        chk("bp_data", y0, 1234);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", int'(out_valid), 1);
            chk("bp_hold_data", $signed(out_data), 1234);
            chk("bp_hold_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", int'(out_valid), 0);
        chk("bp_release_idle", int'(in_ready), 1);

        // clear asserted while the sample sits in MUL
        in_data   = 16'(5000);
        delay     = 10'(4);
        filterMul = 11'(1022);
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("abort_valid", int'(out_valid), 0);
        chk("abort_busy", int'(busy), 1);
        seen = 1'b0;
        n = 0;
        while (busy && n < 3000) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        chk("abort_busy_len", n, 1024);
        chk("abort_no_out", int'(seen), 0);
        run_rows(1, 9, 1'b0);

        // clear wins over a simultaneous input in IDLE
        in_data  = 16'(777);
        in_valid = 1'b1;
        clear    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        clear    = 1'b0;
        chk("clr_vs_in_busy", int'(busy), 1);
        wait_clear_done("clr_vs_in_len");
        run_rows(0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
